reservation_station: RTL and testbench

//  Receives arithmetic and branch ops dispatched by the decoder (rs_valid/rs_type/rs_r*/rs_dep*/rs_rob_id).

---
 rtl/reservation_station_pkg.sv | 45 ++++
 rtl/reservation_station_rs_select.sv | 20 ++
 rtl/reservation_station.sv | 174 +++++++++++++++++
 tb/tb_reservation_station.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared sizing constants, operand record and the broadcast-snoop helper
// used by the reservation station and its selector.
package reservation_station_pkg;

    localparam int RS_SIZE_BIT   = 3;
    localparam int RS_SIZE       = 1 << RS_SIZE_BIT;
    localparam int RS_TYPE_BIT   = 5;
    localparam int ROB_WIDTH_BIT = 4;
    localparam int DATA_W        = 32;

    // One operand slot: still waiting on a ROB entry, or holding its value.
    typedef struct packed {
        logic              pending;
        logic [DATA_W-1:0] value;
    } operand_t;

    // Resolve a waiting operand against both result broadcasts.
    // The ALU broadcast takes priority when both match.
    function automatic operand_t resolve_operand(
        input logic                     pending,
        input logic [ROB_WIDTH_BIT-1:0] tag,
        input logic [DATA_W-1:0]        value,
        input logic                     alu_v,
        input logic [ROB_WIDTH_BIT-1:0] alu_id,
        input logic [DATA_W-1:0]        alu_val,
        input logic                     lsb_v,
        input logic [ROB_WIDTH_BIT-1:0] lsb_id,
        input logic [DATA_W-1:0]        lsb_val
    );
        operand_t r;
        r.pending = pending;
        r.value   = value;
        if (pending) begin
            if (alu_v && (alu_id == tag)) begin
                r.pending = 1'b0;
                r.value   = alu_val;
            end else if (lsb_v && (lsb_id == tag)) begin
                r.pending = 1'b0;
                r.value   = lsb_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Lowest-index priority encoder returning {found, index}.
module rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan from the top so the lowest set request is the last one written.
    always_comb begin
        found = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Eight-entry reservation station: holds dispatched ALU/branch ops until
// both operands are known, snoops ALU and LSB broadcasts, issues one ready
// op per cycle to the ALU.
//
// Dispatch handshake: the decoder samples rs_full, and may present at most
// one more rs_valid after rs_full rises (its dispatch is registered one
// cycle late). rs_full therefore asserts while one slot is still free; an
// rs_valid arriving with no free slot is illegal. rdy_in=0 freezes both
// sides, rob_clear discards any dispatch in the same cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    input  logic                     rs_valid,
    input  logic [RS_TYPE_BIT-1:0]   rs_type,
    input  logic [DATA_W-1:0]        rs_r1,
    input  logic [DATA_W-1:0]        rs_r2,
    input  logic                     rs_has_dep1,
    input  logic                     rs_has_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] rs_dep1,
    input  logic [ROB_WIDTH_BIT-1:0] rs_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    output logic                     rs_full,
    input  logic                     alu_res_valid,
    input  logic [ROB_WIDTH_BIT-1:0] alu_res_rob_id,
    input  logic [DATA_W-1:0]        alu_res_value,
    input  logic                     lsb_res_valid,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_res_rob_id,
    input  logic [DATA_W-1:0]        lsb_res_value,
    output logic                     alu_valid,
    output logic [RS_TYPE_BIT-1:0]   alu_type,
    output logic [DATA_W-1:0]        alu_r1,
    output logic [DATA_W-1:0]        alu_r2,
    output logic [ROB_WIDTH_BIT-1:0] alu_rob_id
);

    logic [RS_SIZE-1:0]       busy;
    logic [RS_SIZE-1:0]       has_q1;
    logic [RS_SIZE-1:0]       has_q2;
    logic [RS_TYPE_BIT-1:0]   ent_type [RS_SIZE];
    logic [DATA_W-1:0]        v1       [RS_SIZE];
    logic [DATA_W-1:0]        v2       [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] q1       [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] q2       [RS_SIZE];
    logic [ROB_WIDTH_BIT-1:0] ent_rob  [RS_SIZE];

    operand_t                 op1_next [RS_SIZE];
    operand_t                 op2_next [RS_SIZE];
    logic [RS_SIZE-1:0]       ready;
    operand_t                 disp1;
    operand_t                 disp2;

    logic                     free_found;
    logic [RS_SIZE_BIT-1:0]   free_idx;
    logic                     issue_found;
    logic [RS_SIZE_BIT-1:0]   issue_idx;
    logic [RS_SIZE_BIT:0]     free_cnt;

    // Per-entry wake-up compare; readiness uses only pre-edge state.
    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry
        assign op1_next[g] = resolve_operand(has_q1[g], q1[g], v1[g],
                                 alu_res_valid, alu_res_rob_id, alu_res_value,
                                 lsb_res_valid, lsb_res_rob_id, lsb_res_value);
        assign op2_next[g] = resolve_operand(has_q2[g], q2[g], v2[g],
                                 alu_res_valid, alu_res_rob_id, alu_res_value,
                                 lsb_res_valid, lsb_res_rob_id, lsb_res_value);
        assign ready[g]    = busy[g] & ~has_q1[g] & ~has_q2[g];
    end

    // Same-cycle forwarding of a broadcast into the op being dispatched.
    assign disp1 = resolve_operand(rs_has_dep1, rs_dep1, rs_r1,
                       alu_res_valid, alu_res_rob_id, alu_res_value,
                       lsb_res_valid, lsb_res_rob_id, lsb_res_value);
    assign disp2 = resolve_operand(rs_has_dep2, rs_dep2, rs_r2,
                       alu_res_valid, alu_res_rob_id, alu_res_value,
                       lsb_res_valid, lsb_res_rob_id, lsb_res_value);

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (~busy),
        .found (free_found),
        .index (free_idx)
    );

    rs_select #(.N(RS_SIZE)) u_issue_sel (
        .req   (ready),
        .found (issue_found),
        .index (issue_idx)
    );

    // Count free slots; full leaves one slot for the decoder's in-flight op.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + (RS_SIZE_BIT + 1)'(!busy[i]);
        end
    end

    assign rs_full = (free_cnt <= (RS_SIZE_BIT + 1)'(1));

    // Entry array: flush, wake-up, issue release and dispatch write.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy   <= '0;
            has_q1 <= '0;
            has_q2 <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_type[i] <= '0;
                v1[i]       <= '0;
                v2[i]       <= '0;
                q1[i]       <= '0;
                q2[i]       <= '0;
                ent_rob[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        has_q1[i] <= op1_next[i].pending;
                        v1[i]     <= op1_next[i].value;
                        has_q2[i] <= op2_next[i].pending;
                        v2[i]     <= op2_next[i].value;
                    end
                end
                if (issue_found) busy[issue_idx] <= 1'b0;
                // Target was free before the edge, so never the issuing entry.
                if (rs_valid && free_found) begin
                    busy[free_idx]     <= 1'b1;
                    ent_type[free_idx] <= rs_type;
                    has_q1[free_idx]   <= disp1.pending;
                    v1[free_idx]       <= disp1.value;
                    q1[free_idx]       <= rs_dep1;
                    has_q2[free_idx]   <= disp2.pending;
                    v2[free_idx]       <= disp2.value;
                    q2[free_idx]       <= rs_dep2;
                    ent_rob[free_idx]  <= rs_rob_id;
                end
            end
        end
    end

    // Registered issue port; data holds when nothing is ready.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_valid  <= 1'b0;
            alu_type   <= '0;
            alu_r1     <= '0;
            alu_r2     <= '0;
            alu_rob_id <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                alu_valid <= 1'b0;
            end else begin
                alu_valid <= issue_found;
                if (issue_found) begin
                    alu_type   <= ent_type[issue_idx];
                    alu_r1     <= v1[issue_idx];
                    alu_r2     <= v2[issue_idx];
                    alu_rob_id <= ent_rob[issue_idx];
                end
            end
        end
    end

    no_dispatch_when_full : assert property (
        @(posedge clk_in) disable iff (!rst_in)
        (rdy_in && !rob_clear && rs_valid) |-> free_found
    );

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for the reservation station: dispatch, wake-up, forward,
// fill/drain ordering, flush, rdy_in freeze and asynchronous reset.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        rs_valid;
    logic [4:0]  rs_type;
    logic [31:0] rs_r1, rs_r2;
    logic        rs_has_dep1, rs_has_dep2;
    logic [3:0]  rs_dep1, rs_dep2, rs_rob_id;
    logic        rs_full;
    logic        alu_res_valid;
    logic [3:0]  alu_res_rob_id;
    logic [31:0] alu_res_value;
    logic        lsb_res_valid;
    logic [3:0]  lsb_res_rob_id;
    logic [31:0] lsb_res_value;
    logic        alu_valid;
    logic [4:0]  alu_type;
    logic [31:0] alu_r1, alu_r2;
    logic [3:0]  alu_rob_id;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .rs_valid(rs_valid), .rs_type(rs_type), .rs_r1(rs_r1), .rs_r2(rs_r2),
        .rs_has_dep1(rs_has_dep1), .rs_has_dep2(rs_has_dep2),
        .rs_dep1(rs_dep1), .rs_dep2(rs_dep2), .rs_rob_id(rs_rob_id),
        .rs_full(rs_full),
        .alu_res_valid(alu_res_valid), .alu_res_rob_id(alu_res_rob_id),
        .alu_res_value(alu_res_value),
        .lsb_res_valid(lsb_res_valid), .lsb_res_rob_id(lsb_res_rob_id),
        .lsb_res_value(lsb_res_value),
        .alu_valid(alu_valid), .alu_type(alu_type), .alu_r1(alu_r1),
        .alu_r2(alu_r2), .alu_rob_id(alu_rob_id)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rob_clear     = 1'b0;
        rs_valid      = 1'b0;
        rs_type       = '0;
        rs_r1         = '0;
        rs_r2         = '0;
        rs_has_dep1   = 1'b0;
        rs_has_dep2   = 1'b0;
        rs_dep1       = '0;
        rs_dep2       = '0;
        rs_rob_id     = '0;
        alu_res_valid = 1'b0;
        alu_res_rob_id = '0;
        alu_res_value = '0;
        lsb_res_valid = 1'b0;
        lsb_res_rob_id = '0;
        lsb_res_value = '0;
    endtask

    task automatic drive_op(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                            input logic hd1, input logic [3:0] d1,
                            input logic hd2, input logic [3:0] d2, input logic [3:0] rob);
        rs_valid    = 1'b1;
        rs_type     = t;
        rs_r1       = a;
        rs_r2       = b;
        rs_has_dep1 = hd1;
        rs_dep1     = d1;
        rs_has_dep2 = hd2;
        rs_dep2     = d2;
        rs_rob_id   = rob;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle_inputs();
        #1;
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", alu_valid); end
        checks++; if (alu_type !== 5'd0) begin errors++; $display("FAIL reset_type got %0h want 0", alu_type); end
        checks++; if (alu_r1 !== 32'd0 || alu_r2 !== 32'd0) begin errors++; $display("FAIL reset_data got %0h/%0h want 0/0", alu_r1, alu_r2); end
        checks++; if (alu_rob_id !== 4'd0) begin errors++; $display("FAIL reset_rob got %0d want 0", alu_rob_id); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", rs_full); end
        step();
        #3 rst_in = 1'b1;
        step();
    endtask

    task automatic test_no_dep();
        drive_op(5'b00000, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL nodep_early got %0b want 0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL nodep_valid got %0b want 1", alu_valid); end
        checks++; if (alu_r1 !== 32'd5 || alu_r2 !== 32'd7) begin errors++; $display("FAIL nodep_data got %0h/%0h want 5/7", alu_r1, alu_r2); end
        checks++; if (alu_rob_id !== 4'd3 || alu_type !== 5'd0) begin errors++; $display("FAIL nodep_rob got %0d/%0h want 3/0", alu_rob_id, alu_type); end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL nodep_idle got %0b want 0", alu_valid); end
        checks++; if (alu_r1 !== 32'd5) begin errors++; $display("FAIL nodep_hold got %0h want 5", alu_r1); end
    endtask

    task automatic test_wakeup();
        drive_op(5'b00111, 32'hdead, 32'h20, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
        step();
        idle_inputs();
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0b want 0", alu_valid); end
        alu_res_valid = 1'b1; alu_res_rob_id = 4'd2; alu_res_value = 32'h10;
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_same_edge got %0b want 0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got %0b want 1", alu_valid); end
        checks++; if (alu_r1 !== 32'h10 || alu_r2 !== 32'h20) begin errors++; $display("FAIL wake_data got %0h/%0h want 10/20", alu_r1, alu_r2); end
        checks++; if (alu_rob_id !== 4'd4 || alu_type !== 5'b00111) begin errors++; $display("FAIL wake_rob got %0d/%0h want 4/7", alu_rob_id, alu_type); end
        step();
    endtask

    task automatic test_forward();
        drive_op(5'b10001, 32'h1, 32'h2, 1'b1, 4'd2, 1'b1, 4'd6, 4'd5);
        alu_res_valid = 1'b1; alu_res_rob_id = 4'd2; alu_res_value = 32'h33;
        lsb_res_valid = 1'b1; lsb_res_rob_id = 4'd6; lsb_res_value = 32'h44;
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL fwd_early got %0b want 0", alu_valid); end
        step();
        checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %0b want 1", alu_valid); end
        checks++; if (alu_r1 !== 32'h33 || alu_r2 !== 32'h44) begin errors++; $display("FAIL fwd_data got %0h/%0h want 33/44", alu_r1, alu_r2); end
        checks++; if (alu_rob_id !== 4'd5) begin errors++; $display("FAIL fwd_rob got %0d want 5", alu_rob_id); end
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) begin
            checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL fill_full_early%0d got %0b want 0", i, rs_full); end
            drive_op(5'(i), 32'd0, 32'(100 + i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
            exp_q.push_back(4'(i));
            step();
        end
        idle_inputs();
        checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", rs_full); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL fill_noissue got %0b want 0", alu_valid); end
        lsb_res_valid = 1'b1; lsb_res_rob_id = 4'd9; lsb_res_value = 32'h99;
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0 || rs_full !== 1'b1) begin errors++; $display("FAIL fill_wake got %0b/%0b want 0/1", alu_valid, rs_full); end
        for (int i = 0; i < 7; i++) begin
            logic [3:0] exp_rob;
            step();
            exp_rob = exp_q.pop_front();
            checks++; if (alu_valid !== 1'b1 || alu_rob_id !== exp_rob) begin errors++; $display("FAIL drain_rob%0d got %0b/%0d want 1/%0d", i, alu_valid, alu_rob_id, exp_rob); end
            checks++; if (alu_r1 !== 32'h99 || alu_r2 !== 32'(100 + i)) begin errors++; $display("FAIL drain_data%0d got %0h/%0d want 99/%0d", i, alu_r1, alu_r2, 100 + i); end
            if (i == 0) begin
                checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL drain_full got %0b want 0", rs_full); end
            end
        end
        step();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL drain_end got %0b want 0", alu_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive_op(5'd1, 32'd0, 32'd0, 1'b1, 4'd11, 1'b0, 4'd0, 4'(i));
            step();
        end
        idle_inputs();
        lsb_res_valid = 1'b1; lsb_res_rob_id = 4'd11; lsb_res_value = 32'h5;
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_pre got %0b want 0", alu_valid); end
        rob_clear = 1'b1;
        drive_op(5'd2, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", alu_valid); end
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL flush_full got %0b want 0", rs_full); end
        alu_res_valid = 1'b1; alu_res_rob_id = 4'd11; alu_res_value = 32'h6;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_inputs();
            checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_late%0d got %0b rob %0d want 0", i, alu_valid, alu_rob_id); end
        end
    endtask

    task automatic test_rdy_freeze();
        drive_op(5'd3, 32'd0, 32'h55, 1'b1, 4'd13, 1'b0, 4'd0, 4'd8);
        step();
        drive_op(5'd4, 32'hA, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
        step();
        idle_inputs();
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob_id !== 4'd14) begin errors++; $display("FAIL frz_pre got %0b/%0d want 1/14", alu_valid, alu_rob_id); end
        rdy_in = 1'b0;
        alu_res_valid = 1'b1; alu_res_rob_id = 4'd13; alu_res_value = 32'h77;
        drive_op(5'd5, 32'h1, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_valid !== 1'b1 || alu_rob_id !== 4'd14 || alu_r1 !== 32'hA) begin errors++; $display("FAIL frz_hold%0d got %0b/%0d/%0h want 1/14/a", i, alu_valid, alu_rob_id, alu_r1); end
        end
        rdy_in = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL frz_after%0d got %0b rob %0d want 0", i, alu_valid, alu_rob_id); end
        end
        alu_res_valid = 1'b1; alu_res_rob_id = 4'd13; alu_res_value = 32'h77;
        step();
        idle_inputs();
        step();
        checks++; if (alu_valid !== 1'b1 || alu_rob_id !== 4'd8 || alu_r1 !== 32'h77) begin errors++; $display("FAIL frz_wake got %0b/%0d/%0h want 1/8/77", alu_valid, alu_rob_id, alu_r1); end
        step();
    endtask

    task automatic test_async_reset();
        drive_op(5'd6, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        step();
        drive_op(5'd6, 32'h3, 32'h4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        step();
        idle_inputs();
        checks++; if (alu_valid !== 1'b1 || alu_rob_id !== 4'd1) begin errors++; $display("FAIL arst_pre got %0b/%0d want 1/1", alu_valid, alu_rob_id); end
        #2 rst_in = 1'b0;
        #1;
        checks++; if (alu_valid !== 1'b0 || alu_rob_id !== 4'd0 || alu_r1 !== 32'd0) begin errors++; $display("FAIL arst_now got %0b/%0d/%0h want 0/0/0", alu_valid, alu_rob_id, alu_r1); end
        step();
        #3 rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (alu_valid !== 1'b0 || rs_full !== 1'b0) begin errors++; $display("FAIL arst_empty%0d got %0b/%0b want 0/0", i, alu_valid, rs_full); end
        end
    endtask

    initial begin
        test_reset();
        test_no_dep();
        test_wakeup();
        test_forward();
        test_fill();
        test_flush();
        test_rdy_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
